regbank_reader: RTL and testbench
=================================

Name: regbank_reader

Overview:
- Read-side responder for the GPU control register bank; it is the other end of the writer/load path that fills the bank.
- Accepts single or burst read requests from the host bridge and returns register words over a valid/ready response channel, one beat per cycle.
- Observes the bank's register outputs presented as a flat bus and never modifies them.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, number of registers in the bank (1..2^AW).
- AW, 4, address width; register index range is 0..2^AW-1.
- LENW, 4, burst length field width; a request returns req_len+1 beats.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- regs_flat  input  WIDTH*NREGS  live register contents; reg i = bits [i*WIDTH +: WIDTH].
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  AW  first register index.
- req_len  input  LENW  beats minus one.
- rsp_valid  output  1  response beat present.
- rsp_ready  input  1  consumer accepts beat.
- rsp_data  output  WIDTH  register word.
- rsp_last  output  1  final beat of burst.
- rsp_err  output  1  beat addressed a nonexistent register (index >= NREGS).
- busy  output  1  burst in progress (state != IDLE).

Behaviour:
- Reset: reset is synchronous and active-low. On a clk edge with reset==0: state=IDLE, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0, counters cleared. req_ready=1 once reset is released.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0. Accept on req_valid&&req_ready; latch cur_addr=req_addr, remain=req_len; go to RESP.
  - RESP: req_ready=0, busy=1.
- Latency: the first beat is registered on the accept edge, so rsp_valid=1 the cycle after accept (1-cycle latency).
- Beat load: rsp_data=regs_flat[cur_addr] if cur_addr<NREGS, else rsp_data=0 and rsp_err=1. rsp_last=(remain==0).
- Handshake:
  - A beat transfers on rsp_valid&&rsp_ready.
  - While rsp_valid&&!rsp_ready, rsp_data, rsp_last and rsp_err hold stable; live register changes are not reflected.
  - On a transfer with remain>0: cur_addr+=1, remain-=1, next beat loaded on the same edge; rsp_valid stays 1. With rsp_ready held high this gives one beat per cycle.
  - On a transfer with rsp_last=1: rsp_valid=0, go to IDLE. req_ready=1 the following cycle; no accept on the same edge as the last transfer.
- Address arithmetic: cur_addr increments modulo 2^AW and wraps 2^AW-1 -> 0. The error check applies per beat.
- Burst length: req_len=0 gives one beat; the maximum is 2^LENW beats.
- req_valid during RESP is ignored, since req_ready=0; the requester must hold it.
- Reset asserted mid-burst: the burst aborts on that edge, rsp_valid=0, and no further beats are produced.

Optional Feature:
- Macro: REGBANK_READER_SNAPSHOT_EN.
- Defined: on the request accept edge, all NREGS words of regs_flat are copied into an internal shadow bank. Every beat of that burst reads the shadow, so the burst is coherent even if the registers change mid-burst. The shadow clears to 0 on reset.
- Undefined: no shadow storage. Each beat samples live regs_flat on the edge the beat is loaded.

Test Plan:
- Single read: regs[3]=0xDEADBEEF; req addr=3 len=0 with rsp_ready=1 -> one cycle after accept, rsp_valid=1, rsp_data=0xDEADBEEF, rsp_last=1, rsp_err=0; req_ready=1 two cycles after accept.
- Full-rate burst: regs[i]=0x100+i; req addr=2 len=3 with rsp_ready=1 -> 4 consecutive beats 0x102,0x103,0x104,0x105; rsp_last only on 0x105.
- Backpressure: burst addr=0 len=1; rsp_ready=0 for 5 cycles, then 1 -> first beat held stable for 5 cycles. Without the macro, change regs[0] during the stall: held data is unchanged. Then regs[1] is delivered.
- Wrap and error with NREGS=12: req addr=10 len=5 -> beats idx 10,11 (valid data, err=0), then 12,13,14,15 (data=0, err=1); with a 6-beat burst no wrap occurs. Separately, addr=15 len=1 -> idx 15 (err=1) then idx 0 (valid).
- Reset mid-burst: addr=0 len=7, pull reset low after beat 2 -> next edge rsp_valid=0, busy=0; after release req_ready=1 and a new single request works normally.
- Snapshot with REGBANK_READER_SNAPSHOT_EN: burst addr=0 len=3; overwrite regs[2]=0xAA after accept -> beat 2 returns the pre-accept value. Without the macro it returns 0xAA.

Source files
------------

// File: rtl/regbank_reader.sv
// rtl/regbank_reader.sv - burst read responder for the GPU control register bank
// Optional shadow snapshot of the bank per burst: REGBANK_READER_SNAPSHOT_EN
module regbank_reader #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int LENW  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH*NREGS-1:0] regs_flat,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [LENW-1:0]        req_len,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam int NSLOTS = 2 ** AW;
  localparam logic [AW:0] NREGS_LIM = (AW + 1)'(NREGS);

  state_t          state, state_next;
  logic [AW-1:0]   cur_addr;
  logic [LENW-1:0] remain;

  logic            accept;
  logic            load;
  logic [AW-1:0]   load_addr;
  logic [LENW-1:0] load_remain;
  logic [WIDTH-1:0] load_word;
  logic            load_err;

  // Full 2^AW view of the bank; slots past NREGS read as zero.
  logic [WIDTH-1:0] live [NSLOTS];
  for (genvar i = 0; i < NSLOTS; i++) begin : g_live
    if (i < NREGS) begin : g_reg
      assign live[i] = regs_flat[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign live[i] = '0;
    end
  end

`ifdef REGBANK_READER_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow [NSLOTS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSLOTS; i++) shadow[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NSLOTS; i++) shadow[i] <= live[i];
    end
  end

  // First beat loads on the accept edge, before the shadow holds the copy.
  assign load_word = (state == RESP) ? shadow[load_addr] : live[load_addr];
`else
  assign load_word = live[load_addr];
`endif

  assign load_err  = {1'b0, load_addr} >= NREGS_LIM;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state == RESP);

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load        = 1'b0;
    load_addr   = cur_addr;
    load_remain = remain;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept      = 1'b1;
          load        = 1'b1;
          load_addr   = req_addr;
          load_remain = req_len;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_next = IDLE;
          end else begin
            load        = 1'b1;
            load_addr   = cur_addr + AW'(1);
            load_remain = remain - LENW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr <= '0;
      remain   <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (load) begin
      cur_addr <= load_addr;
      remain   <= load_remain;
      rsp_data <= load_err ? '0 : load_word;
      rsp_last <= (load_remain == '0);
      rsp_err  <= load_err;
    end
  end

endmodule

// File: tb/tb_regbank_reader.sv
// tb/tb_regbank_reader.sv - randomized and directed checks of regbank_reader against a bank model
module tb_regbank_reader;

  localparam int WIDTH = 32;
  localparam int NREGS = 12;
  localparam int AW    = 4;
  localparam int LENW  = 4;

  logic                   clk;
  logic                   reset;
  logic [WIDTH*NREGS-1:0] regs_flat;
  logic                   req_valid;
  logic                   req_ready;
  logic [AW-1:0]          req_addr;
  logic [LENW-1:0]        req_len;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_last;
  logic                   rsp_err;
  logic                   busy;

  logic [WIDTH-1:0] regs [NREGS];
  int checks = 0;
  int errors = 0;

  regbank_reader #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .regs_flat(regs_flat),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
  );

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: beat k of a burst reads index (addr+k) mod 2^AW; indices past the bank are errors.
  task automatic do_burst(input int addr, input int len, input bit rand_ready);
    logic [WIDTH-1:0] exp_data [$];
    bit               exp_err  [$];
    int beats, cyc, idx;
    bit rdy;
    for (int k = 0; k <= len; k++) begin
      idx = (addr + k) % (2 ** AW);
      exp_err.push_back(idx >= NREGS);
      exp_data.push_back(idx >= NREGS ? '0 : regs[idx]);
    end
    check("req_ready_idle", req_ready, 1);
    req_addr  = AW'(addr);
    req_len   = LENW'(len);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats <= len && cyc < 100) begin
      check("rsp_valid", rsp_valid, 1);
      check("busy", busy, 1);
      check("req_ready_busy", req_ready, 0);
      check("rsp_data", rsp_data, exp_data[beats]);
      check("rsp_err", rsp_err, exp_err[beats]);
      check("rsp_last", rsp_last, beats == len);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp_ready = rdy;
      tick();
      if (rdy) beats++;
      cyc++;
    end
    check("beats_delivered", beats, len + 1);
    check("rsp_valid_end", rsp_valid, 0);
    check("req_ready_end", req_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] held, orig2;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_rsp_err", rsp_err, 0);
    reset = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);

    // Single read, full-rate burst, wrap/error cases.
    regs[3] = 32'hDEADBEEF;
    do_burst(3, 0, 0);
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h100 + i;
    do_burst(2, 3, 0);
    do_burst(10, 5, 0);
    do_burst(15, 1, 0);

    // Backpressure: beat 0 must hold through a live register change.
    rsp_ready = 1'b0;
    req_addr  = '0;
    req_len   = LENW'(1);
    req_valid = 1'b1;
    held      = regs[0];
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) regs[0] = 32'h5555_0000;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, held);
      check("bp_last", rsp_last, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_beat1_valid", rsp_valid, 1);
    check("bp_beat1_data", rsp_data, regs[1]);
    check("bp_beat1_last", rsp_last, 1);
    tick();
    check("bp_done", rsp_valid, 0);

    // Reset mid-burst.
    rsp_ready = 1'b1;
    req_addr  = '0;
    req_len   = LENW'(7);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check("mid_data", rsp_data, regs[b]);
      tick();
    end
    reset = 1'b0;
    tick();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", req_ready, 1);
    do_burst(5, 0, 0);

    // Coherence: regs[2] overwritten right after accept.
    orig2     = 32'h1234_5678;
    regs[2]   = orig2;
    rsp_ready = 1'b1;
    req_addr  = '0;
    req_len   = LENW'(3);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    regs[2] = 32'hAA;
    tick();
    tick();
    check("snap_valid", rsp_valid, 1);
`ifdef REGBANK_READER_SNAPSHOT_EN
    check("snap_beat2", rsp_data, orig2);
`else
    check("snap_beat2", rsp_data, 32'hAA);
`endif
    tick();
    tick();
    check("snap_done", rsp_valid, 0);

    // Randomized bursts with random backpressure.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      do_burst($urandom_range(0, 2 ** AW - 1), $urandom_range(0, 2 ** LENW - 1), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
